frame_rd_scheduler: RTL and testbench
=====================================

Name: frame_rd_scheduler

Overview:
- Sequences the read side of the frame buffer.
- Chooses which stored frame to play out and splits each frame into fixed-length AXI4 read burst commands.
- Issues a burst to the AXI4 read master only when the backward FIFO (the one feeding the FIFO→AXIS stage) has room for the whole burst.
- Sits between the writer's frame-complete pulses, the AXI4 read master command port, and the FIFO fill count.

Parameters:
- ADDR_WIDTH, 32, byte address width of commands.
- FAW, 8, FIFO address width; FIFO depth is 2^FAW words of AXI4_DATA_WIDTH.
- AXI4_DATA_WIDTH, 128, width of one AXI4 beat / FIFO word.
- PIXELS_HORIZONTAL, 1280, 32-bit pixels per line.
- PIXELS_VERTICAL, 1024, lines per frame.
- FRAME_BUF_NUM, 3, number of frame buffers in memory (2..4).
- FRAME_BASE, 32'h0000_0000, byte address of buffer 0.
- FRAME_STRIDE, 32'h0050_0000, byte distance between buffers.
- BURST_LEN, 16, beats per burst; must divide LINE_BEATS.
- FRAME_DELAY, 2, completed frames required before the first read (1..1023).

Ports:
- ACLK  in  1  single clock.
- ARESET  in  1  synchronous, active-high reset.
- wr_frame_done  in  1  one-cycle pulse: writer finished the buffer given by wr_frame_idx.
- wr_frame_idx  in  2  index of the buffer just completed.
- rd_frame_start  in  1  one-cycle pulse from output timing: begin the next output frame.
- fifo_cnt  in  FAW+1  current backward-FIFO fill level, in words.
- cmd_valid  out  1  burst command valid.
- cmd_ready  in  1  read master accepts the command.
- cmd_addr  out  ADDR_WIDTH  burst start byte address.
- cmd_len  out  8  AXI ARLEN value, BURST_LEN-1.
- cmd_done  in  1  one-cycle pulse: all beats of the outstanding burst have been written into the FIFO.
- rd_frame_idx  out  2  buffer currently being read.
- rd_active  out  1  a frame is being fetched.
- frame_repeat  out  1  one-cycle pulse: the frame just started reuses the previous buffer.

Behaviour:
- Derived constants (package):
  - LINE_BEATS = PIXELS_HORIZONTAL*32/AXI4_DATA_WIDTH (320 at defaults).
  - BURSTS_PER_LINE = LINE_BEATS/BURST_LEN.
  - BURST_BYTES = BURST_LEN*AXI4_DATA_WIDTH/8.
- Reset values:
  - cmd_valid=0, cmd_addr=0, cmd_len=BURST_LEN-1 (constant), rd_frame_idx=0, rd_active=0, frame_repeat=0.
  - Internal counters 0; state IDLE.
- Frame bookkeeping:
  - done_cnt (10 b) increments on wr_frame_done and saturates at FRAME_DELAY.
  - last_done_idx latches wr_frame_idx on wr_frame_done.
  - new_flag sets on wr_frame_done and clears when a frame is latched for reading.
- FSM states: IDLE, ARM, WAIT_SPACE, ISSUE, WAIT_DONE.
- IDLE → ARM: on rd_frame_start with done_cnt==FRAME_DELAY. Before that, rd_frame_start is ignored.
- ARM (1 cycle):
  - rd_frame_idx <= last_done_idx.
  - frame_repeat pulses if new_flag==0.
  - burst_cnt, line_cnt <= 0; addr <= FRAME_BASE + last_done_idx*FRAME_STRIDE.
  - rd_active <= 1 → WAIT_SPACE.
- WAIT_SPACE: go to ISSUE when (2^FAW - fifo_cnt) >= BURST_LEN. The comparison is combinational on the current fifo_cnt.
- ISSUE:
  - cmd_valid=1 with cmd_addr=addr.
  - Address and valid stay stable until cmd_ready (AXI rule: no retraction).
  - On handshake → WAIT_DONE; addr += BURST_BYTES.
- WAIT_DONE: only one burst is outstanding at a time. On cmd_done:
  - Advance burst_cnt; on wrap at BURSTS_PER_LINE, advance line_cnt.
  - If this was the last burst of line PIXELS_VERTICAL-1 → IDLE with rd_active <= 0.
  - Otherwise → WAIT_SPACE.
  - Line addresses are contiguous: no line padding, so addr simply keeps incrementing.
- rd_frame_start while rd_active=1:
  - Latch restart_pend; the current burst handshake and its cmd_done complete normally.
  - On the next exit from WAIT_DONE, go to ARM instead of WAIT_SPACE.
- Simultaneous events:
  - wr_frame_done in the same cycle as ARM: the ARM uses the previous last_done_idx, and new_flag stays set for the next frame.
  - cmd_done asserted outside WAIT_DONE is ignored.
- ARESET mid-burst: state is dropped immediately and cmd_valid goes low the next cycle. The system resets the read master together with this block.

Optional Feature:
- Macro FRS_STATUS_CNT_EN.
- Defined: adds output ports repeat_cnt[15:0] (counts frame_repeat pulses) and restart_cnt[15:0] (counts mid-frame rd_frame_start events). Both wrap at 16 bits and clear on ARESET.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package frs_pkg holds:
  - the state enum;
  - the LINE_BEATS, BURSTS_PER_LINE and BURST_BYTES functions;
  - the clogb2 function.
- One natural sub-module, frs_frame_tracker: done_cnt, last_done_idx, new_flag, and the frame-selection output used in ARM.

Test Plan (bench params: PIXELS_HORIZONTAL=64, PIXELS_VERTICAL=4, BURST_LEN=4, FAW=4, FRAME_DELAY=2, FRAME_BUF_NUM=3, FRAME_STRIDE=32'h1000):
- Start gating: one wr_frame_done(idx 0), then rd_frame_start → no cmd_valid. A second done(idx 1) plus rd_frame_start → first cmd_addr=0x1000, rd_frame_idx=1.
- Full frame:
  - Setup: fifo_cnt=0, cmd_ready=1, cmd_done 3 cycles after each handshake.
  - Expect 16 commands with addresses 0x1000, 0x1040, … 0x13C0.
  - rd_active then falls; no 17th command.
- Backpressure:
  - fifo_cnt=13 → cmd_valid stays 0.
  - fifo_cnt drops to 12 → cmd_valid=1 next cycle.
  - cmd_ready held low 5 cycles → cmd_addr stable throughout.
- Repeat: a second rd_frame_start with no new wr_frame_done → frame_repeat pulses once, rd_frame_idx stays 1, addresses restart at 0x1000.
- Mid-frame restart:
  - done(idx 2), then rd_frame_start during burst 5 → burst 5 completes.
  - Next command address is 0x2000; with the macro defined, restart_cnt=1.
- ARESET asserted while cmd_valid=1 → cmd_valid=0 and rd_active=0 the next cycle, and rd_frame_start is ignored until two new wr_frame_done pulses.

Source files
------------

// File: rtl/frs_pkg.sv
// frs_pkg -- shared types and helper functions for the frame read scheduler.
//
// Contents:
//   frs_state_e      scheduler FSM state encoding
//   line_beats()     AXI beats needed for one line of 32-bit pixels
//   bursts_per_line()  bursts needed for one line
//   burst_bytes()    byte size of one burst
//   clogb2()         ceil(log2(n)), never less than 1, for sizing counters
package frs_pkg;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_ARM        = 3'd1,
      S_WAIT_SPACE = 3'd2,
      S_ISSUE      = 3'd3,
      S_WAIT_DONE  = 3'd4
   } frs_state_e;

   function automatic int line_beats(input int pixels_h, input int data_w);
      return (pixels_h * 32) / data_w;
   endfunction

   function automatic int bursts_per_line(input int pixels_h, input int data_w,
                                          input int burst_len);
      return line_beats(pixels_h, data_w) / burst_len;
   endfunction

   function automatic int burst_bytes(input int burst_len, input int data_w);
      return (burst_len * data_w) / 8;
   endfunction

   function automatic int clogb2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) begin
         r = r + 1;
      end
      if (r < 1) begin
         r = 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/frs_frame_tracker.sv
// frs_frame_tracker -- remembers which frame buffer the writer completed last
// and whether enough frames exist to start reading.
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   wr_frame_done_i    writer finished buffer wr_frame_idx_i (1-cycle pulse)
//   wr_frame_idx_i     index of the buffer just completed
//   arm_i              scheduler is latching a frame for reading this cycle
//   start_ok_o         FRAME_DELAY frames have completed since reset
//   sel_idx_o          buffer to read on the next ARM (last completed one)
//   sel_new_o          sel_idx_o has not been read yet (0 -> frame repeat)
module frs_frame_tracker #(
   parameter int FRAME_DELAY   = 2,
   parameter int FRAME_BUF_NUM = 3
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       wr_frame_done_i,
   input  logic [1:0] wr_frame_idx_i,
   input  logic       arm_i,
   output logic       start_ok_o,
   output logic [1:0] sel_idx_o,
   output logic       sel_new_o
);

   localparam logic [9:0] DELAY_C   = 10'(FRAME_DELAY);
   localparam logic [2:0] MAX_IDX_C = 3'(FRAME_BUF_NUM - 1);

   logic [9:0] done_cnt_q, done_cnt_d;
   logic [1:0] last_idx_q, last_idx_d;
   logic       new_flag_q, new_flag_d;

   always_comb begin
      done_cnt_d = done_cnt_q;
      last_idx_d = last_idx_q;
      new_flag_d = new_flag_q;
      if (wr_frame_done_i) begin
         if (done_cnt_q != DELAY_C) begin
            done_cnt_d = done_cnt_q + 10'd1;
         end
         // An index past the last allocated buffer would read unrelated
         // memory; pin it to the highest real buffer instead.
         if ({1'b0, wr_frame_idx_i} <= MAX_IDX_C) begin
            last_idx_d = wr_frame_idx_i;
         end else begin
            last_idx_d = MAX_IDX_C[1:0];
         end
      end
      // A completion in the same cycle as ARM belongs to the next frame, so
      // setting wins over the clear.
      if (wr_frame_done_i) begin
         new_flag_d = 1'b1;
      end else if (arm_i) begin
         new_flag_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         done_cnt_q <= '0;
         last_idx_q <= '0;
         new_flag_q <= 1'b0;
      end else begin
         done_cnt_q <= done_cnt_d;
         last_idx_q <= last_idx_d;
         new_flag_q <= new_flag_d;
      end
   end

   assign start_ok_o = (done_cnt_q == DELAY_C);
   assign sel_idx_o  = last_idx_q;
   assign sel_new_o  = new_flag_q;

endmodule

// File: rtl/frame_rd_scheduler.sv
// frame_rd_scheduler -- read-side sequencer of the frame buffer. Picks the
// most recently completed frame buffer, splits it into fixed-length AXI4 read
// bursts and issues one burst at a time, only when the downstream FIFO has
// room for the whole burst.
//
// Optional feature macro: FRS_STATUS_CNT_EN adds repeat_cnt / restart_cnt.
//
// Ports:
//   ACLK, ARESET      clock, synchronous active-high reset
//   wr_frame_done     writer finished buffer wr_frame_idx (1-cycle pulse)
//   wr_frame_idx      index of the buffer just completed
//   rd_frame_start    output timing requests the next frame (1-cycle pulse)
//   fifo_cnt          backward FIFO fill level in words
//   cmd_valid/ready   burst command handshake
//   cmd_addr, cmd_len burst start byte address, ARLEN (BURST_LEN-1)
//   cmd_done          all beats of the outstanding burst are in the FIFO
//   rd_frame_idx      buffer currently being read
//   rd_active         a frame is being fetched
//   frame_repeat      1-cycle pulse: new frame reuses the previous buffer
//   repeat_cnt        (macro) number of frame_repeat pulses, wraps
//   restart_cnt       (macro) number of mid-frame rd_frame_start events, wraps
//   dbg_state_o       current FSM state
//
// Command handshake: cmd_valid is raised only in ISSUE; cmd_addr and
// cmd_valid hold steady until the cycle cmd_ready is seen high, and the
// command transfers on a clock edge where both are high.
module frame_rd_scheduler
   import frs_pkg::*;
#(
   parameter int                    ADDR_WIDTH        = 32,
   parameter int                    FAW               = 8,
   parameter int                    AXI4_DATA_WIDTH   = 128,
   parameter int                    PIXELS_HORIZONTAL = 1280,
   parameter int                    PIXELS_VERTICAL   = 1024,
   parameter int                    FRAME_BUF_NUM     = 3,
   parameter logic [ADDR_WIDTH-1:0] FRAME_BASE        = 32'h0000_0000,
   parameter logic [ADDR_WIDTH-1:0] FRAME_STRIDE      = 32'h0050_0000,
   parameter int                    BURST_LEN         = 16,
   parameter int                    FRAME_DELAY       = 2
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   input  logic                  wr_frame_done,
   input  logic [1:0]            wr_frame_idx,
   input  logic                  rd_frame_start,
   input  logic [FAW:0]          fifo_cnt,
   output logic                  cmd_valid,
   input  logic                  cmd_ready,
   output logic [ADDR_WIDTH-1:0] cmd_addr,
   output logic [7:0]            cmd_len,
   input  logic                  cmd_done,
   output logic [1:0]            rd_frame_idx,
   output logic                  rd_active,
   output logic                  frame_repeat,
`ifdef FRS_STATUS_CNT_EN
   output logic [15:0]           repeat_cnt,
   output logic [15:0]           restart_cnt,
`endif
   output frs_state_e            dbg_state_o
);

   localparam int BPL = bursts_per_line(PIXELS_HORIZONTAL, AXI4_DATA_WIDTH, BURST_LEN);
   localparam int BCW = clogb2(BPL);
   localparam int LCW = clogb2(PIXELS_VERTICAL);
   // Highest fill level that still leaves room for one whole burst.
   localparam logic [FAW:0] SPACE_LIM_C = (FAW+1)'((1 << FAW) - BURST_LEN);
   localparam logic [ADDR_WIDTH-1:0] BURST_BYTES_C =
      ADDR_WIDTH'(burst_bytes(BURST_LEN, AXI4_DATA_WIDTH));

   frs_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [BCW-1:0]        burst_q, burst_d;
   logic [LCW-1:0]        line_q, line_d;
   logic [1:0]            rd_idx_q, rd_idx_d;
   logic                  rd_active_q, rd_active_d;
   logic                  frame_repeat_q, frame_repeat_d;
   logic                  restart_pend_q, restart_pend_d;

   logic                  start_ok;
   logic [1:0]            sel_idx;
   logic                  sel_new;
   logic                  arm;
   logic                  space_ok;
   logic                  done_exit;
   logic                  last_burst;
   logic                  frame_end;
   logic                  restart_evt;
   logic [ADDR_WIDTH-1:0] frame_addr;

   assign arm         = (state_q == S_ARM);
   assign space_ok    = (fifo_cnt <= SPACE_LIM_C);
   assign done_exit   = (state_q == S_WAIT_DONE) && cmd_done;
   assign last_burst  = (burst_q == BCW'(BPL - 1));
   assign frame_end   = last_burst && (line_q == LCW'(PIXELS_VERTICAL - 1));
   assign restart_evt = rd_frame_start && rd_active_q;
   assign frame_addr  = FRAME_BASE + (ADDR_WIDTH'(sel_idx) * FRAME_STRIDE);

   frs_frame_tracker #(
      .FRAME_DELAY   (FRAME_DELAY),
      .FRAME_BUF_NUM (FRAME_BUF_NUM)
   ) u_tracker (
      .clk_i           (ACLK),
      .rst_i           (ARESET),
      .wr_frame_done_i (wr_frame_done),
      .wr_frame_idx_i  (wr_frame_idx),
      .arm_i           (arm),
      .start_ok_o      (start_ok),
      .sel_idx_o       (sel_idx),
      .sel_new_o       (sel_new)
   );

   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      burst_d        = burst_q;
      line_d         = line_q;
      rd_idx_d       = rd_idx_q;
      rd_active_d    = rd_active_q;
      frame_repeat_d = 1'b0;
      restart_pend_d = restart_pend_q;

      case (state_q)
         S_IDLE: begin
            if (rd_frame_start && start_ok) begin
               state_d = S_ARM;
            end
         end
         S_ARM: begin
            rd_idx_d       = sel_idx;
            frame_repeat_d = !sel_new;
            burst_d        = '0;
            line_d         = '0;
            addr_d         = frame_addr;
            rd_active_d    = 1'b1;
            state_d        = S_WAIT_SPACE;
         end
         S_WAIT_SPACE: begin
            if (space_ok) begin
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (cmd_ready) begin
               addr_d  = addr_q + BURST_BYTES_C;
               state_d = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            if (cmd_done) begin
               if (last_burst) begin
                  burst_d = '0;
                  line_d  = line_q + LCW'(1);
               end else begin
                  burst_d = burst_q + BCW'(1);
               end
               // A start request pending, or arriving right now, takes over
               // at the burst boundary, even on the last burst of a frame.
               if (restart_pend_q || rd_frame_start) begin
                  restart_pend_d = 1'b0;
                  state_d        = S_ARM;
               end else if (frame_end) begin
                  rd_active_d = 1'b0;
                  state_d     = S_IDLE;
               end else begin
                  state_d = S_WAIT_SPACE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (restart_evt && !done_exit) begin
         restart_pend_d = 1'b1;
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q        <= S_IDLE;
         addr_q         <= '0;
         burst_q        <= '0;
         line_q         <= '0;
         rd_idx_q       <= '0;
         rd_active_q    <= 1'b0;
         frame_repeat_q <= 1'b0;
         restart_pend_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         addr_q         <= addr_d;
         burst_q        <= burst_d;
         line_q         <= line_d;
         rd_idx_q       <= rd_idx_d;
         rd_active_q    <= rd_active_d;
         frame_repeat_q <= frame_repeat_d;
         restart_pend_q <= restart_pend_d;
      end
   end

`ifdef FRS_STATUS_CNT_EN
   logic [15:0] repeat_cnt_q, restart_cnt_q;

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         repeat_cnt_q  <= '0;
         restart_cnt_q <= '0;
      end else begin
         if (frame_repeat_q) begin
            repeat_cnt_q <= repeat_cnt_q + 16'd1;
         end
         if (restart_evt) begin
            restart_cnt_q <= restart_cnt_q + 16'd1;
         end
      end
   end

   assign repeat_cnt  = repeat_cnt_q;
   assign restart_cnt = restart_cnt_q;
`endif

   assign cmd_valid    = (state_q == S_ISSUE);
   assign cmd_addr     = addr_q;
   assign cmd_len      = 8'(BURST_LEN - 1);
   assign rd_frame_idx = rd_idx_q;
   assign rd_active    = rd_active_q;
   assign frame_repeat = frame_repeat_q;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_frame_rd_scheduler.sv
module tb_frame_rd_scheduler;
   import frs_pkg::*;

   localparam int          FAW    = 4;
   localparam int          BB     = 64;   // 4 beats * 16 bytes
   localparam logic [31:0] STRIDE = 32'h1000;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst;
   logic        wr_frame_done;
   logic [1:0]  wr_frame_idx;
   logic        rd_frame_start;
   logic [FAW:0] fifo_cnt;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_addr;
   logic [7:0]  cmd_len;
   logic        cmd_done;
   logic [1:0]  rd_frame_idx;
   logic        rd_active;
   logic        frame_repeat;
   frs_state_e  dbg_state;
`ifdef FRS_STATUS_CNT_EN
   logic [15:0] repeat_cnt;
   logic [15:0] restart_cnt;
`endif

   always #5 clk = ~clk;

   frame_rd_scheduler #(
      .ADDR_WIDTH        (32),
      .FAW               (FAW),
      .AXI4_DATA_WIDTH   (128),
      .PIXELS_HORIZONTAL (64),
      .PIXELS_VERTICAL   (4),
      .FRAME_BUF_NUM     (3),
      .FRAME_BASE        (32'h0),
      .FRAME_STRIDE      (STRIDE),
      .BURST_LEN         (4),
      .FRAME_DELAY       (2)
   ) dut (
      .ACLK           (clk),
      .ARESET         (rst),
      .wr_frame_done  (wr_frame_done),
      .wr_frame_idx   (wr_frame_idx),
      .rd_frame_start (rd_frame_start),
      .fifo_cnt       (fifo_cnt),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_addr       (cmd_addr),
      .cmd_len        (cmd_len),
      .cmd_done       (cmd_done),
      .rd_frame_idx   (rd_frame_idx),
      .rd_active      (rd_active),
      .frame_repeat   (frame_repeat),
`ifdef FRS_STATUS_CNT_EN
      .repeat_cnt     (repeat_cnt),
      .restart_cnt    (restart_cnt),
`endif
      .dbg_state_o    (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   int          hs_cnt = 0;
   int          rep_cnt = 0;
   int          done_timer = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted command is compared with the next expected one.
   always @(negedge clk) begin
      if (!rst) begin
         if (frame_repeat) rep_cnt++;
         if (cmd_valid && cmd_ready) begin
            hs_cnt++;
            check("cmd_len", {24'h0, cmd_len}, 32'd3);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_cmd: got 0x%0h expected none", cmd_addr);
            end else begin
               check("cmd_addr", cmd_addr, exp_q.pop_front());
            end
         end
      end
   end

   // Read-master model: cmd_done three cycles after each accepted command.
   always @(negedge clk) begin
      cmd_done = 1'b0;
      if (rst) begin
         done_timer = 0;
      end else begin
         if (done_timer != 0) begin
            done_timer--;
            if (done_timer == 0) cmd_done = 1'b1;
         end
         if (cmd_valid && cmd_ready) done_timer = 3;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_done(input logic [1:0] idx);
      wr_frame_done = 1'b1;
      wr_frame_idx  = idx;
      tick();
      wr_frame_done = 1'b0;
   endtask

   task automatic pulse_start();
      rd_frame_start = 1'b1;
      tick();
      rd_frame_start = 1'b0;
   endtask

   task automatic push_frame(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(i * BB));
   endtask

   task automatic wait_active(input logic lvl, input string name);
      int k;
      k = 0;
      while (rd_active !== lvl && k < 2000) begin
         tick();
         k++;
      end
      check(name, {31'h0, rd_active}, {31'h0, lvl});
   endtask

   task automatic wait_hs(input int target, input string name);
      int k;
      k = 0;
      while (hs_cnt < target && k < 2000) begin
         tick();
         k++;
      end
      check(name, {31'h0, (hs_cnt >= target)}, 32'd1);
   endtask

   task automatic expect_no_valid(input int n, input string name);
      logic seen;
      seen = 1'b0;
      repeat (n) begin
         tick();
         if (cmd_valid) seen = 1'b1;
      end
      check(name, {31'h0, seen}, 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic stable;
      int   base;
      int   k;

      rst = 1'b1;
      wr_frame_done = 1'b0;
      wr_frame_idx = 2'd0;
      rd_frame_start = 1'b0;
      fifo_cnt = '0;
      cmd_ready = 1'b1;
      tick(3);
      check("rst_cmd_valid", {31'h0, cmd_valid}, 32'd0);
      check("rst_cmd_addr", cmd_addr, 32'h0);
      check("rst_cmd_len", {24'h0, cmd_len}, 32'd3);
      check("rst_rd_idx", {30'h0, rd_frame_idx}, 32'd0);
      check("rst_rd_active", {31'h0, rd_active}, 32'd0);
      check("rst_frame_repeat", {31'h0, frame_repeat}, 32'd0);
      rst = 1'b0;
      tick();

      // Start gating: one completed frame is not enough.
      pulse_done(2'd0);
      pulse_start();
      expect_no_valid(6, "gate_one_frame");
      check("gate_rd_active", {31'h0, rd_active}, 32'd0);

      // Full frame from buffer 1.
      pulse_done(2'd1);
      push_frame(32'h1000, 16);
      pulse_start();
      wait_active(1'b1, "f1_active_rise");
      check("f1_rd_idx", {30'h0, rd_frame_idx}, 32'd1);
      check("f1_no_repeat", {31'h0, frame_repeat}, 32'd0);
      wait_active(1'b0, "f1_active_fall");
      expect_no_valid(8, "f1_no_17th_cmd");
      check("f1_queue_empty", exp_q.size(), 32'd0);
      check("f1_hs_count", hs_cnt, 32'd16);
      check("f1_rep_cnt", rep_cnt, 32'd0);

      // Backpressure on a repeated frame.
      fifo_cnt = 13;
      cmd_ready = 1'b0;
      push_frame(32'h1000, 16);
      pulse_start();
      wait_active(1'b1, "bp_active_rise");
      check("bp_repeat_pulse", {31'h0, frame_repeat}, 32'd1);
      expect_no_valid(8, "bp_fifo13_hold");
      fifo_cnt = 12;
      tick();
      check("bp_fifo12_valid", {31'h0, cmd_valid}, 32'd1);
      stable = 1'b1;
      repeat (5) begin
         tick();
         if (!cmd_valid || cmd_addr !== 32'h1000) stable = 1'b0;
      end
      check("bp_addr_stable", {31'h0, stable}, 32'd1);
      cmd_ready = 1'b1;
      fifo_cnt = 0;
      wait_active(1'b0, "bp_active_fall");
      check("bp_rd_idx", {30'h0, rd_frame_idx}, 32'd1);
      check("bp_rep_cnt", rep_cnt, 32'd1);
      check("bp_queue_empty", exp_q.size(), 32'd0);

      // Mid-frame restart: repeat of buffer 1, buffer 2 completes, restart at burst 5.
      push_frame(32'h1000, 5);
      push_frame(32'h2000, 16);
      base = hs_cnt;
      pulse_start();
      wait_hs(base + 1, "rs_first_burst");
      pulse_done(2'd2);
      wait_hs(base + 5, "rs_fifth_burst");
      pulse_start();
      wait_active(1'b0, "rs_active_fall");
      check("rs_rd_idx", {30'h0, rd_frame_idx}, 32'd2);
      check("rs_queue_empty", exp_q.size(), 32'd0);
      check("rs_rep_cnt", rep_cnt, 32'd2);
`ifdef FRS_STATUS_CNT_EN
      check("rs_restart_cnt", {16'h0, restart_cnt}, 32'd1);
      check("rs_repeat_cnt", {16'h0, repeat_cnt}, 32'd2);
`endif

      // Reset while a command is pending.
      cmd_ready = 1'b0;
      pulse_start();
      k = 0;
      while (!cmd_valid && k < 200) begin
         tick();
         k++;
      end
      check("ar_pre_valid", {31'h0, cmd_valid}, 32'd1);
      rst = 1'b1;
      tick();
      check("ar_cmd_valid", {31'h0, cmd_valid}, 32'd0);
      check("ar_rd_active", {31'h0, rd_active}, 32'd0);
      check("ar_rd_idx", {30'h0, rd_frame_idx}, 32'd0);
`ifdef FRS_STATUS_CNT_EN
      check("ar_restart_cnt", {16'h0, restart_cnt}, 32'd0);
`endif
      rst = 1'b0;
      cmd_ready = 1'b1;
      tick();
      pulse_start();
      expect_no_valid(6, "ar_gate_zero");
      pulse_done(2'd0);
      pulse_start();
      expect_no_valid(6, "ar_gate_one");
      pulse_done(2'd2);
      push_frame(32'h2000, 16);
      pulse_start();
      wait_active(1'b1, "ar_active_rise");
      check("ar_no_repeat", {31'h0, frame_repeat}, 32'd0);
      wait_active(1'b0, "ar_active_fall");
      check("ar_final_idx", {30'h0, rd_frame_idx}, 32'd2);
      check("ar_queue_empty", exp_q.size(), 32'd0);

      tick(4);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
